seg_scan_decoder: RTL and testbench

//  Receive side of the multiplexed 7-segment display interface. Samples the scanned

---
 rtl/seg_scan_decoder_pkg.sv | 60 ++++++
 rtl/seg_scan_decoder_if.sv | 21 ++
 rtl/seg_scan_decoder_stable_filter.sv | 54 +++++
 rtl/seg_scan_decoder.sv | 131 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Segment codes, digit positions and the decode helpers shared by the scan
// driver and the scan decoder.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIG_SEP_LO    = 3'd2;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd3;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd4;
    localparam logic [2:0] DIG_SEP_HI    = 3'd5;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd6;
    localparam logic [2:0] DIG_HOUR_TENS = 3'd7;

    typedef enum logic [1:0] {SYM_DIGIT, SYM_SEP, SYM_BLANK, SYM_BAD} sym_kind_t;

    typedef struct packed {
        sym_kind_t  kind;
        logic [3:0] value;
    } seg_sym_t;

    function automatic seg_sym_t seg_decode(input logic [6:0] code);
        seg_sym_t sym;
        sym.kind  = SYM_DIGIT;
        sym.value = 4'd0;
        case (code)
            SEG_0:     sym.value = 4'd0;
            SEG_1:     sym.value = 4'd1;
            SEG_2:     sym.value = 4'd2;
            SEG_3:     sym.value = 4'd3;
            SEG_4:     sym.value = 4'd4;
            SEG_5:     sym.value = 4'd5;
            SEG_6:     sym.value = 4'd6;
            SEG_7:     sym.value = 4'd7;
            SEG_8:     sym.value = 4'd8;
            SEG_9:     sym.value = 4'd9;
            SEG_DASH:  sym.kind  = SYM_SEP;
            SEG_BLANK: sym.kind  = SYM_BLANK;
            default:   sym.kind  = SYM_BAD;
        endcase
        return sym;
    endfunction

    function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Observed display scan lines plus the decoded time and status seen by the consumer.
interface seg_scan_decoder_if;
    logic [7:0] select_dig;
    logic [7:0] select_seg;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic       frame_valid;
    logic       frame_err;
    logic       stalled;

    modport master (
        output select_dig, select_seg,
        input  sec, min, hour, frame_valid, frame_err, stalled
    );

    modport slave (
        input  select_dig, select_seg,
        output sec, min, hour, frame_valid, frame_err, stalled
    );
endinterface

// File: rtl/seg_scan_decoder_stable_filter.sv
// Polarity-normalises the scan lines and emits one strobe per run of
// STABLE_CYCLES identical samples, hiding ghosting at digit transitions.
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 8,
    parameter int DIG_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW   = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] select_dig,
    input  logic [7:0] select_seg,
    output logic       stable,
    output logic [7:0] dig,
    output logic [6:0] seg
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [7:0]    dig_now;
    logic [7:0]    seg_now;
    logic [7:0]    dig_prev;
    logic [7:0]    seg_prev;
    logic [CW-1:0] count;
    logic          captured;

    // The dp bit takes part in the change detection even though decode ignores it.
    always_ff @(posedge clk) begin
        if (clear) begin
            dig_now  <= '0;
            seg_now  <= '0;
            dig_prev <= '0;
            seg_prev <= '0;
            count    <= '0;
            captured <= 1'b0;
        end else begin
            dig_now  <= (DIG_ACT_LOW != 0) ? ~select_dig : select_dig;
            seg_now  <= (SEG_ACT_LOW != 0) ? ~select_seg : select_seg;
            dig_prev <= dig_now;
            seg_prev <= seg_now;
            if (dig_now != dig_prev || seg_now != seg_prev) begin
                count    <= '0;
                captured <= 1'b0;
            end else if (stable) begin
                captured <= 1'b1;
            end else if (count != LAST) begin
                count <= count + 1'b1;
            end
        end
    end

    assign stable = (count == LAST) && !captured;
    assign dig    = dig_prev;
    assign seg    = seg_prev[6:0];
endmodule

// File: rtl/seg_scan_decoder.sv
// Readback monitor for the multiplexed HH-MM-SS display: filters the scan,
// decodes each digit and publishes a binary time once all eight were seen.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT       = 96000,
    parameter int DIG_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW   = 1
) (
    input  logic               clk_48mhz,
    input  logic               clear,
    seg_scan_decoder_if.slave  scan
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          stable;
    logic [7:0]    dig;
    logic [6:0]    seg;
    logic          multi;
    logic          capture;
    logic          strobe_err;
    logic [2:0]    idx;
    seg_sym_t      sym;
    logic          digit_err;
    logic [3:0]    digit_val;
    logic [3:0]    digits [8];
    logic [7:0]    mask;
    logic          err_acc;
    logic [6:0]    sec_full;
    logic [6:0]    min_full;
    logic [6:0]    hour_full;
    logic          range_err;
    logic [TW-1:0] idle_count;
    logic [5:0]    sec_q;
    logic [5:0]    min_q;
    logic [5:0]    hour_q;
    logic          valid_q;
    logic          err_q;
    logic          stalled_q;

    seg_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .DIG_ACT_LOW   (DIG_ACT_LOW),
        .SEG_ACT_LOW   (SEG_ACT_LOW)
    ) u_filter (
        .clk        (clk_48mhz),
        .clear      (clear),
        .select_dig (scan.select_dig),
        .select_seg (scan.select_seg),
        .stable     (stable),
        .dig        (dig),
        .seg        (seg)
    );

    assign multi      = |(dig & (dig - 8'd1));
    assign capture    = stable && (dig != 8'd0) && !multi;
    assign strobe_err = stable && multi;
    assign sym        = seg_decode(seg);

    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (dig[i]) idx = 3'(i);
        end
    end

    // A blank leading hour digit is how the driver shows hours below ten.
    always_comb begin
        digit_err = 1'b0;
        digit_val = sym.value;
        if (idx == DIG_SEP_LO || idx == DIG_SEP_HI) begin
            digit_err = (sym.kind != SYM_SEP);
        end else if (idx == DIG_HOUR_TENS && sym.kind == SYM_BLANK) begin
            digit_val = 4'd0;
        end else begin
            digit_err = (sym.kind != SYM_DIGIT);
        end
    end

    assign sec_full  = bcd_pair(digits[DIG_SEC_TENS], digits[DIG_SEC_ONES]);
    assign min_full  = bcd_pair(digits[DIG_MIN_TENS], digits[DIG_MIN_ONES]);
    assign hour_full = bcd_pair(digits[DIG_HOUR_TENS], digits[DIG_HOUR_ONES]);
    assign range_err = (sec_full > 7'd59) || (min_full > 7'd59) || (hour_full > 7'd23);

    // A capture coinciding with frame completion seeds the next frame.
    always_ff @(posedge clk_48mhz) begin
        if (clear) begin
            mask    <= '0;
            err_acc <= 1'b0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) digits[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            if (mask == 8'hFF) begin
                sec_q   <= sec_full[5:0];
                min_q   <= min_full[5:0];
                hour_q  <= hour_full[5:0];
                valid_q <= 1'b1;
                err_q   <= err_acc | range_err;
                mask    <= capture ? (8'd1 << idx) : 8'd0;
                err_acc <= (capture && digit_err) || strobe_err;
            end else begin
                if (capture) mask[idx] <= 1'b1;
                if ((capture && digit_err) || strobe_err) err_acc <= 1'b1;
            end
            if (capture) digits[idx] <= digit_val;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (clear || capture) begin
            idle_count <= '0;
            stalled_q  <= 1'b0;
        end else if (idle_count != TW'(TIMEOUT)) begin
            idle_count <= idle_count + 1'b1;
            stalled_q  <= (idle_count == TW'(TIMEOUT - 1));
        end
    end

    assign scan.sec         = sec_q;
    assign scan.min         = min_q;
    assign scan.hour        = hour_q;
    assign scan.frame_valid = valid_q;
    assign scan.frame_err   = err_q;
    assign scan.stalled     = stalled_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised scan stimulus for seg_scan_decoder, scored against a digit-level
// model of the display frame built directly from the segment table.
module tb_seg_scan_decoder;
   localparam int STABLE  = 8;
   localparam int TIMEOUT = 2000;
   localparam int DWELL   = 40;

   logic clk_48mhz = 1'b0;
   logic clear;
   int unsigned cyc = 0;
   int unsigned lastChange = 0;
   int checks = 0;
   int failures = 0;

   seg_scan_decoder_if scan();

   seg_scan_decoder #(
      .STABLE_CYCLES (STABLE),
      .TIMEOUT       (TIMEOUT),
      .DIG_ACT_LOW   (1),
      .SEG_ACT_LOW   (1)
   ) dut (
      .clk_48mhz (clk_48mhz),
      .clear     (clear),
      .scan      (scan)
   );

   always #5 clk_48mhz = ~clk_48mhz;
   always @(posedge clk_48mhz) cyc <= cyc + 1;

   typedef struct {
      int hour;
      int min;
      int sec;
      bit err;
      bit chk;
   } frame_t;

   logic [6:0] codeTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [7:0] frameCodes [8];
   int numPos [5] = '{0, 1, 3, 4, 6};
   frame_t expQ [$];
   int mVal [8];
   bit mSeen [8];
   bit mErr;
   bit mBad;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 8; k++) begin
         mSeen[k] = 1'b0;
         mVal[k] = 0;
      end
      mErr = 1'b0;
      mBad = 1'b0;
      expQ.delete();
   endtask

   // A hold of at least STABLE cycles is one observed digit.
   task automatic modelHold(input logic [7:0] dig, input logic [7:0] seg, input int cycles);
      int ones;
      int pos;
      int sym;
      bit all;
      frame_t f;
      if (cycles < STABLE) return;
      ones = $countones(dig);
      if (ones == 0) return;
      if (ones > 1) begin
         mErr = 1'b1;
         return;
      end
      pos = 0;
      for (int k = 0; k < 8; k++) if (dig[k]) pos = k;
      sym = 12;
      for (int k = 0; k < 10; k++) if (seg[6:0] == codeTab[k]) sym = k;
      if (seg[6:0] == 7'h40) sym = 10;
      if (seg[6:0] == 7'h00) sym = 11;
      if (pos == 2 || pos == 5) begin
         if (sym != 10) mErr = 1'b1;
      end else if (sym <= 9) begin
         mVal[pos] = sym;
      end else if (pos == 7 && sym == 11) begin
         mVal[pos] = 0;
      end else begin
         mErr = 1'b1;
         mBad = 1'b1;
         mVal[pos] = 0;
      end
      mSeen[pos] = 1'b1;
      all = 1'b1;
      for (int k = 0; k < 8; k++) if (!mSeen[k]) all = 1'b0;
      if (all) begin
         f.hour = mVal[7] * 10 + mVal[6];
         f.min  = mVal[4] * 10 + mVal[3];
         f.sec  = mVal[1] * 10 + mVal[0];
         f.err  = mErr || f.hour > 23 || f.min > 59 || f.sec > 59;
         f.chk  = !mBad;
         f.hour = f.hour % 64;
         f.min  = f.min % 64;
         f.sec  = f.sec % 64;
         expQ.push_back(f);
         for (int k = 0; k < 8; k++) mSeen[k] = 1'b0;
         mErr = 1'b0;
         mBad = 1'b0;
      end
   endtask

   // Inputs are given in active-high form and driven inverted onto the lines.
   task automatic applyStimulus(input logic [7:0] dig, input logic [7:0] seg, input int cycles);
      scan.select_dig = ~dig;
      scan.select_seg = ~seg;
      lastChange = cyc;
      modelHold(dig, seg, cycles);
      repeat (cycles) @(negedge clk_48mhz);
   endtask

   task automatic buildCodes(input int h, input int m, input int s);
      frameCodes[0] = {1'b0, codeTab[s % 10]};
      frameCodes[1] = {1'b0, codeTab[s / 10]};
      frameCodes[2] = 8'h40;
      frameCodes[3] = {1'b0, codeTab[m % 10]};
      frameCodes[4] = {1'b0, codeTab[m / 10]};
      frameCodes[5] = 8'h40;
      frameCodes[6] = {1'b0, codeTab[h % 10]};
      frameCodes[7] = {1'b0, codeTab[h / 10]};
   endtask

   task automatic scanDigits(input int first, input int last, input bit glitch);
      for (int p = first; p <= last; p++) begin
         if (glitch) applyStimulus(8'(1 << p), 8'h7F, 3);
         applyStimulus(8'(1 << p), frameCodes[p], DWELL);
      end
   endtask

   // Every published frame is matched against the oldest predicted one.
   always @(negedge clk_48mhz) begin
      frame_t f;
      if (scan.frame_valid === 1'b1) begin
         checkOutput("frame_expected", 32'(expQ.size() > 0), 1);
         checkOutput("stalled_in_scan", 32'(scan.stalled), 0);
         if (expQ.size() > 0) begin
            f = expQ.pop_front();
            checkOutput("frame_err", 32'(scan.frame_err), 32'(f.err));
            if (f.chk) begin
               checkOutput("hour", 32'(scan.hour), f.hour);
               checkOutput("min", 32'(scan.min), f.min);
               checkOutput("sec", 32'(scan.sec), f.sec);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int h;
      int m;
      int s;
      int kind;
      int p;
      int lat;
      bit rose;

      modelReset();
      clear = 1'b1;
      scan.select_dig = 8'hFF;
      scan.select_seg = 8'hFF;
      repeat (4) @(negedge clk_48mhz);
      checkOutput("reset_sec", 32'(scan.sec), 0);
      checkOutput("reset_min", 32'(scan.min), 0);
      checkOutput("reset_hour", 32'(scan.hour), 0);
      checkOutput("reset_valid", 32'(scan.frame_valid), 0);
      checkOutput("reset_err", 32'(scan.frame_err), 0);
      checkOutput("reset_stalled", 32'(scan.stalled), 0);
      clear = 1'b0;

      buildCodes(12, 34, 56);
      scanDigits(0, 7, 0);
      scanDigits(0, 7, 0);
      scanDigits(0, 7, 1);

      buildCodes(12, 34, 56);
      frameCodes[0] = 8'h77;
      scanDigits(0, 7, 0);
      buildCodes(12, 34, 56);
      scanDigits(0, 7, 0);

      scanDigits(0, 3, 0);
      applyStimulus(8'b0000_0011, frameCodes[0], 500);
      scanDigits(4, 7, 0);

      buildCodes(7, 5, 9);
      frameCodes[7] = 8'h00;
      scanDigits(0, 7, 1);

      for (int n = 0; n < 24; n++) begin
         h = $urandom_range(23);
         m = $urandom_range(59);
         s = $urandom_range(59);
         buildCodes(h, m, s);
         kind = $urandom_range(7);
         p = numPos[$urandom_range(4)];
         case (kind)
            0: frameCodes[4] = {1'b0, codeTab[$urandom_range(9, 6)]};
            1: frameCodes[7] = {1'b0, codeTab[$urandom_range(9, 2)]};
            2: frameCodes[2] = {1'b0, codeTab[$urandom_range(9)]};
            3: frameCodes[p] = 8'h77;
            4: if (h < 10) frameCodes[7] = 8'h00;
            5: frameCodes[p] = 8'h00;
            default: ;
         endcase
         for (int k = 0; k < 8; k++) frameCodes[k][7] = 1'($urandom_range(1));
         scanDigits(0, 7, 1'($urandom_range(1)));
      end

      buildCodes(9, 8, 7);
      scanDigits(0, 3, 0);
      checkOutput("stalled_before_freeze", 32'(scan.stalled), 0);
      rose = 1'b0;
      lat = 0;
      for (int i = 0; i < TIMEOUT + 200 && !rose; i++) begin
         @(negedge clk_48mhz);
         if (scan.stalled === 1'b1) begin
            rose = 1'b1;
            lat = int'(cyc - lastChange);
         end
      end
      checkOutput("stall_rise", 32'(rose), 1);
      checkOutput("stall_latency_window", 32'(lat >= TIMEOUT + STABLE - 1 && lat <= TIMEOUT + STABLE + 4), 1);
      repeat (100) @(negedge clk_48mhz);
      checkOutput("stall_hold", 32'(scan.stalled), 1);
      applyStimulus(8'h10, frameCodes[4], STABLE + 3);
      checkOutput("stall_drop", 32'(scan.stalled), 0);
      scanDigits(5, 7, 0);

      buildCodes(21, 43, 5);
      scanDigits(0, 4, 0);
      clear = 1'b1;
      repeat (3) @(negedge clk_48mhz);
      checkOutput("clear_sec", 32'(scan.sec), 0);
      checkOutput("clear_min", 32'(scan.min), 0);
      checkOutput("clear_hour", 32'(scan.hour), 0);
      checkOutput("clear_valid", 32'(scan.frame_valid), 0);
      checkOutput("clear_err", 32'(scan.frame_err), 0);
      modelReset();
      clear = 1'b0;
      scanDigits(5, 7, 0);
      scanDigits(0, 4, 0);

      repeat (50) @(negedge clk_48mhz);
      checkOutput("pending_frames", 32'(expQ.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
